// File: rtl/i2c_frame_pkg.sv
// i2c_frame_pkg -- shared constants and types for the I2C frame assembler.
//   FRAME_BYTES  : bytes per frame (start byte + 12 payload bytes)
//   START_PREFIX : upper six bits that mark a start byte
//   op_e         : operation encodings carried in the start byte's low bits
//   state_e      : assembler FSM states
package i2c_frame_pkg;

  localparam int FRAME_BYTES = 13;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int IDX_W       = 4;

  localparam logic [5:0] START_PREFIX = 6'b111111;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  function automatic logic is_start(input logic [7:0] b);
    return b[7:2] == START_PREFIX;
  endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// frame_timeout_ctr -- idle-cycle counter used to abort stalled frames.
// Only instantiated when FRAME_TIMEOUT_EN is defined.
//   clk, rst   : clock, async active-high reset
//   en_i       : assembler is collecting; counter is held at zero otherwise
//   clear_i    : a byte arrived this cycle; restart the idle count
//   expired_o  : this cycle is the TIMEOUT_CYCLES-th consecutive idle cycle
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of idle edges already seen, so the edge that
  // would make it TIMEOUT_CYCLES is the expiry edge.
  assign expired_o = en_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clear_i)  cnt_d = '0;
    else if (!expired_o)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_frame_assembler.sv
// i2c_frame_assembler -- collects 13-byte frames from an I2C slave receiver.
// A byte whose top six bits are all ones starts a frame; the next 12 bytes are
// taken verbatim. The completed frame is held with frame_valid until accepted.
//   clk, rst      : clock, async active-high reset
//   byte_in       : received byte, qualified by byte_valid (1-cycle strobe)
//   frame         : assembled frame, start byte at [103:96]
//   frame_valid   : frame held, waiting for frame_ready
//   frame_ready   : consumer handshake
//   op            : frame[97:96]
//   busy          : collecting a frame
//   overflow      : sticky, a byte arrived while a frame was pending
//   drop_count    : non-start bytes discarded while idle, saturating
//   timeout_err   : one-cycle pulse when a partial frame is aborted
// Optional: define FRAME_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES idle
// cycles between bytes; otherwise collection waits forever.
module i2c_frame_assembler
  import i2c_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [1:0]         op,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic               timeout_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;
  logic               take_idle;
  logic               abort;

`ifdef FRAME_TIMEOUT_EN
  logic expired;
  logic tmo_q;

  frame_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_ctr (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == COLLECT),
    .clear_i   (byte_valid),
    .expired_o (expired)
  );

  // expired is already masked by byte_valid, so an arriving byte wins.
  assign abort = (state_q == COLLECT) && expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= abort;
  end

  assign timeout_err = tmo_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    take_idle = 1'b0;

    unique case (state_q)
      IDLE: take_idle = byte_valid;

      COLLECT: begin
        if (byte_valid) begin
          for (int i = 0; i < FRAME_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) frame_d[(FRAME_BYTES-1-i)*8 +: 8] = byte_in;
          end
          if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end

      HOLD: begin
        // Acceptance frees the buffer this same cycle, so a coincident byte
        // is handled exactly as if we were already idle.
        if (frame_ready) begin
          state_d   = IDLE;
          take_idle = byte_valid;
        end else if (byte_valid) begin
          ovf_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (take_idle) begin
      if (is_start(byte_in)) begin
        frame_d[FRAME_W-1 -: 8] = byte_in;
        idx_d                   = IDX_W'(1);
        state_d                 = COLLECT;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign frame       = frame_q;
  assign op          = frame_q[97:96];
  assign frame_valid = (state_q == HOLD);
  assign busy        = (state_q == COLLECT);
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_i2c_frame_assembler.sv
// Self-checking bench for i2c_frame_assembler: directed scenarios plus a
// randomized run compared cycle-by-cycle against a queue-based reference model.
// Build with FRAME_TIMEOUT_EN defined to exercise the timeout feature.
module tb_i2c_frame_assembler;

  localparam int TMO = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         frame_ready = 1'b0;
  logic [103:0] frame;
  logic         frame_valid, busy, overflow, timeout_err;
  logic [1:0]   op;
  logic [7:0]   drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  i2c_frame_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .op          (op),
    .busy        (busy),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [117:0] dut_vec;
  assign dut_vec = {frame, op, frame_valid, busy, overflow, drop_count, timeout_err};

  // ---------------- reference model ----------------
  logic [103:0] m_frame;
  logic [7:0]   m_q[$];     // bytes of the frame being collected
  bit           m_coll, m_hold, m_ovf, m_tmo;
  int           m_drop, m_idle;

  function automatic void m_reset();
    m_frame = '0; m_q.delete();
    m_coll = 0; m_hold = 0; m_ovf = 0; m_tmo = 0;
    m_drop = 0; m_idle = 0;
  endfunction

  function automatic void m_edge(bit bv, logic [7:0] b, bit rdy);
    bit as_idle = 0;
    m_tmo = 0;
    if (m_hold) begin
      if (rdy) begin m_hold = 0; as_idle = 1; end
      else if (bv) m_ovf = 1;
    end else if (m_coll) begin
      if (bv) begin
        m_frame[103 - 8*m_q.size() -: 8] = b;
        m_q.push_back(b);
        m_idle = 0;
        if (m_q.size() == 13) begin m_coll = 0; m_hold = 1; end
      end else begin
        m_idle++;
`ifdef FRAME_TIMEOUT_EN
        if (m_idle == TMO) begin m_coll = 0; m_tmo = 1; end
`endif
      end
    end else begin
      as_idle = 1;
    end
    if (as_idle && bv) begin
      if (b[7:2] == 6'h3F) begin
        m_q.delete(); m_q.push_back(b);
        m_frame[103:96] = b; m_coll = 1; m_idle = 0;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endfunction

  function automatic logic [117:0] m_vec();
    return {m_frame, m_frame[97:96], m_hold, m_coll, m_ovf, 8'(m_drop), m_tmo};
  endfunction

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit bv, input logic [7:0] b, input bit rdy);
    byte_valid = bv; byte_in = b; frame_ready = rdy;
    @(posedge clk);
    m_edge(bv, b, rdy);
    @(negedge clk);
    byte_valid = 0; frame_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; byte_valid = 0; frame_ready = 0;
    #2;
    rst = 0;
    m_reset();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_chk++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_async: got %h want 0", dut_vec); end
    @(posedge clk); #1;
    n_chk++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", dut_vec); end
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic test_basic_frame();
    logic [7:0] v [13];
    v = '{8'hFE, 8'h20, 8'h20, 8'h00, 8'h00, 8'h3F, 8'h00,
          8'h00, 8'h00, 8'h40, 8'h80, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(1, v[i], 0);
      if (i == 11) begin
        n_chk++;
        if (frame_valid !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL basic_early: valid=%b busy=%b want 0,1", frame_valid, busy);
        end
      end
    end
    n_chk++;
    if (frame !== 104'hFE_20200000_3F000000_40800000) begin
      n_fail++; $display("FAIL basic_frame: got %h want fe202000003f00000040800000", frame);
    end
    n_chk++;
    if (op !== 2'b10 || frame_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_ctrl: op=%b valid=%b busy=%b want 10,1,0", op, frame_valid, busy);
    end
    cyc(0, 8'h00, 1);
    n_chk++;
    if (frame_valid !== 1'b0 || frame !== 104'hFE_20200000_3F000000_40800000) begin
      n_fail++; $display("FAIL basic_accept: valid=%b frame=%h want 0, unchanged", frame_valid, frame);
    end
  endtask

  task automatic test_drops();
    do_reset();
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h0F, 0);
    n_chk++;
    if (drop_count !== 8'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_two: drop=%0d busy=%b want 2,0", drop_count, busy);
    end
    cyc(1, 8'hFC, 0);
    for (int i = 0; i < 12; i++) cyc(1, 8'h00, 0);
    n_chk++;
    if (frame !== {8'hFC, 96'h0} || op !== 2'b00 || drop_count !== 8'd2 || frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_frame: frame=%h op=%b drop=%0d valid=%b want fc00..,00,2,1",
                         frame, op, drop_count, frame_valid);
    end
    cyc(0, 8'h00, 1);
  endtask

  task automatic test_overflow();
    logic [103:0] exp = '0;
    logic [7:0]   b;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      b = (i == 0) ? 8'hFD : 8'($urandom);
      exp = {exp[95:0], b};
      cyc(1, b, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0);
    cyc(1, 8'hAA, 0);
    n_chk++;
    if (frame !== exp || frame_valid !== 1'b1 || overflow !== 1'b1 || op !== 2'b01) begin
      n_fail++; $display("FAIL ovf_hold: frame=%h valid=%b ovf=%b op=%b want %h,1,1,01",
                         frame, frame_valid, overflow, op, exp);
    end
    cyc(0, 8'h00, 1);
    n_chk++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1 || frame !== exp) begin
      n_fail++; $display("FAIL ovf_accept: valid=%b busy=%b ovf=%b want 0,0,1", frame_valid, busy, overflow);
    end
    cyc(1, 8'h11, 0);
    n_chk++;
    if (drop_count !== 8'd1) begin
      n_fail++; $display("FAIL ovf_idle: drop=%0d want 1", drop_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 8'hFF, 0);
    for (int i = 0; i < 12; i++) cyc(1, 8'h55, 0);
    cyc(1, 8'hFC, 1);  // accept and start together
    n_chk++;
    if (frame_valid !== 1'b0 || busy !== 1'b1 || frame[103:96] !== 8'hFC || overflow !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start: valid=%b busy=%b top=%h ovf=%b want 0,1,fc,0",
                         frame_valid, busy, frame[103:96], overflow);
    end
    for (int i = 0; i < 12; i++) cyc(1, 8'h33, 0);
    cyc(1, 8'h12, 1);  // accept with a non-start byte
    n_chk++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd1 || frame !== {8'hFC, {12{8'h33}}}) begin
      n_fail++; $display("FAIL b2b_drop: valid=%b busy=%b drop=%0d frame=%h", frame_valid, busy, drop_count, frame);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    cyc(1, 8'hFE, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'hA5, 0);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1;
    #2;
    n_chk++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL mid_reset: got %h want 0", dut_vec); end
    @(posedge clk); #1;
    n_chk++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL mid_reset_tmo: got %h want 0", dut_vec); end
    @(negedge clk);
    rst = 0;
    m_reset();
    cyc(1, 8'hFF, 0);
    for (int i = 1; i < 13; i++) cyc(1, 8'(i), 0);
    n_chk++;
    if (frame !== 104'hFF_0102030405060708090A0B0C || op !== 2'b11 || frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_refill: frame=%h op=%b valid=%b", frame, op, frame_valid);
    end
    cyc(0, 8'h00, 1);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, 8'($urandom_range(0, 251)), 0);
      if (i == 99 || i == 254) begin
        n_chk++;
        if (drop_count !== 8'(i + 1)) begin
          n_fail++; $display("FAIL sat_mid: drop=%0d want %0d", drop_count, i + 1);
        end
      end
    end
    n_chk++;
    if (drop_count !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sat_end: drop=%0d busy=%b want 255,0", drop_count, busy);
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cyc(1, 8'hFE, 0); cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    for (int k = 1; k <= TMO + 1; k++) begin
      cyc(0, 8'h00, 0);
      n_chk++;
      if (timeout_err !== (k == TMO) || busy !== (k < TMO)) begin
        n_fail++; $display("FAIL tmo_pulse k=%0d: tmo=%b busy=%b want %b,%b",
                           k, timeout_err, busy, k == TMO, k < TMO);
      end
    end
    cyc(1, 8'hFE, 0);
    n_chk++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_restart: busy=%b tmo=%b want 1,0", busy, timeout_err);
    end
    for (int k = 1; k < TMO; k++) cyc(0, 8'h00, 0);
    cyc(1, 8'h33, 0);  // lands on the expiry edge
    n_chk++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_byte_wins: busy=%b tmo=%b want 1,0", busy, timeout_err);
    end
    for (int k = 1; k <= TMO; k++) cyc(0, 8'h00, 0);
    n_chk++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || frame[95:88] !== 8'h33) begin
      n_fail++; $display("FAIL tmo_second: tmo=%b busy=%b byte1=%h want 1,0,33", timeout_err, busy, frame[95:88]);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    cyc(1, 8'hFE, 0); cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    for (int k = 1; k <= 3 * TMO; k++) begin
      cyc(0, 8'h00, 0);
      if (k % TMO == 0) begin
        n_chk++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL no_tmo k=%0d: tmo=%b busy=%b want 0,1", k, timeout_err, busy);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    bit         bv, rdy;
    logic [7:0] b;
    int         errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bv  = ((i / 1000) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      b   = ($urandom_range(0, 2) == 0) ? {6'h3F, 2'($urandom_range(0, 3))} : 8'($urandom);
      rdy = ($urandom_range(0, 3) == 0);
      cyc(bv, b, rdy);
      n_chk++;
      if (dut_vec !== m_vec()) begin
        n_fail++;
        if (errs < 10) $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, m_vec());
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_drops();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_saturate();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_frame_assembler.md
I2C_FRAME_ASSEMBLER -- requirements
Module: i2c_frame_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of idle clk cycles allowed between payload bytes of one frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  byte from the I2C slave receiver.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe; byte_in valid this cycle.
REQ-006 SHALL have port frame  output  104  assembled frame; the start byte is at [103:96], later bytes follow MSB-first.
REQ-007 SHALL have port frame_valid  output  1  frame held valid until accepted.
REQ-008 SHALL have port frame_ready  input  1  consumer accepts frame when high together with frame_valid.
REQ-009 SHALL have port op  output  2  operation code, equal to frame[97:96].
REQ-010 SHALL have port busy  output  1  high while a frame is being collected.
REQ-011 SHALL have port overflow  output  1  sticky; a byte was lost while frame_valid was pending.
REQ-012 SHALL have port drop_count  output  8  count of bytes discarded in IDLE; saturates at 255.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-014 SHALL implement three states: IDLE, COLLECT, HOLD.
REQ-015 In IDLE, a byte_valid whose byte_in[7:2]==6'b111111 SHALL be stored as frame[103:96], clear the byte index to 1, and move to COLLECT.
REQ-016 In IDLE, any other byte_valid SHALL be discarded and increment drop_count (no wrap past 255).
REQ-017 In COLLECT, every byte_valid SHALL be stored at byte position index (bits [103-8*index -: 8]) regardless of value; start-pattern bytes are treated as data.
REQ-018 Storing the 13th byte (index 12) SHALL move to HOLD, and frame_valid SHALL rise on the next cycle (1-cycle latency from the last byte_valid).
REQ-019 In HOLD, frame, op and frame_valid SHALL remain stable until a cycle with frame_valid and frame_ready both high; that cycle SHALL return to IDLE.
REQ-020 A byte_valid during HOLD SHALL be dropped and set overflow; overflow clears only on reset.
REQ-021 Acceptance in HOLD and byte_valid in the same cycle SHALL process the byte as in IDLE on that cycle.
REQ-022 frame SHALL keep its last value after acceptance until overwritten by the next start byte.
REQ-023 busy SHALL be high exactly in COLLECT.

Reset
REQ-024 rst SHALL asynchronously force IDLE, frame=0, op=0, frame_valid=0, busy=0, overflow=0, drop_count=0, timeout_err=0, index=0.
REQ-025 rst asserted mid-frame SHALL discard the partial frame with no timeout_err pulse.

Configuration
REQ-026 With macro FRAME_TIMEOUT_EN defined, in COLLECT an idle counter SHALL reset on each byte_valid; on reaching TIMEOUT_CYCLES it SHALL return to IDLE and pulse timeout_err for one cycle.
REQ-027 If byte_valid coincides with timeout expiry, the byte SHALL win: store it and reset the counter.
REQ-028 Without FRAME_TIMEOUT_EN, no counter logic SHALL exist, timeout_err SHALL be tied 0, and COLLECT waits indefinitely.

Structure
REQ-029 Package i2c_frame_pkg SHALL hold FRAME_BYTES=13, START_PREFIX=6'b111111, op encodings ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11, and the state enum.
REQ-030 The idle counter SHALL be a sub-module frame_timeout_ctr, instantiated only under FRAME_TIMEOUT_EN.

Verification
REQ-031 Bytes FE,20,20,00,00,3F,00,00,00,40,80,00,00 -> frame=0xFE_20200000_3F000000_40800000, op=2'b10, frame_valid high 1 cycle after the 13th strobe.
REQ-032 Bytes F0,0F, then FC plus 12 zero bytes -> drop_count=2, frame=0xFC followed by 96 zero bits, op=2'b00.
REQ-033 Complete frame with frame_ready held low, then byte AA -> frame unchanged, overflow=1; raise frame_ready -> frame_valid falls, state IDLE.
REQ-034 FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=50: FE,01,02 then silence -> timeout_err pulse 50 cycles after byte 02, busy=0; a following FE restarts collection.
REQ-035 rst pulsed after 6 bytes of a frame -> all outputs 0, no timeout_err; a following full frame assembles correctly.
REQ-036 300 non-start bytes in IDLE -> drop_count saturates at 255.
